// File: rtl/data_sram_responder_if.sv
// SRAM-like data port between a core (master) and the data RAM responder (slave).
interface data_sram_responder_if;
    logic        data_req;
    logic        data_wr;
    logic [2:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/data_sram_responder.sv
// Word-addressed data RAM behind an SRAM-like port: pipelined accepts, in-order
// responses after a fixed latency, bounded by an outstanding-request queue.
module data_sram_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 4,
    parameter int LATENCY    = 2
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        stall_i,
    data_sram_responder_if.slave        bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int WORDS  = 2 ** ADDR_WIDTH;
    localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [WAIT_W-1:0] INIT_WAIT  = WAIT_W'(LATENCY - 1);

    logic [31:0]           r_mem       [WORDS];
    logic                  r_qWr       [DEPTH];
    logic [31:0]           r_qData     [DEPTH];
    logic [WAIT_W-1:0]     r_qWait     [DEPTH];
    logic [PTR_W-1:0]      r_wrPtr;
    logic [PTR_W-1:0]      r_rdPtr;
    logic [CNT_W-1:0]      r_count;

    logic                  w_qWrNext   [DEPTH];
    logic [31:0]           w_qDataNext [DEPTH];
    logic [WAIT_W-1:0]     w_qWaitNext [DEPTH];
    logic [ADDR_WIDTH-1:0] w_wordIdx;
    logic [31:0]           w_memWord;
    logic [31:0]           w_mergedWord;
    logic                  w_addrOk;
    logic                  w_accept;
    logic                  w_dataOk;
    logic                  w_unused;

    // Address low bits, high bits and the size field are deliberately ignored.
    assign w_wordIdx = bus.data_addr[ADDR_WIDTH+1:2];
    assign w_unused  = ^{bus.data_size, bus.data_addr[31:ADDR_WIDTH+2], bus.data_addr[1:0]};
    assign w_memWord = r_mem[w_wordIdx];

    // No full-bypass: a pop in the same cycle does not reopen a full queue.
    assign w_addrOk = resetn && (r_count != FULL_COUNT) && !stall_i;
    assign w_accept = bus.data_req && w_addrOk;
    assign w_dataOk = resetn && (r_count != '0) && (r_qWait[r_rdPtr] == '0);

    assign bus.data_addr_ok = w_addrOk;
    assign bus.data_data_ok = w_dataOk;
    assign bus.data_rdata   = (w_dataOk && !r_qWr[r_rdPtr]) ? r_qData[r_rdPtr] : 32'd0;

    always_comb begin
        w_mergedWord = w_memWord;
        for (int b = 0; b < 4; b++) begin
            if (bus.data_wstrb[b]) begin
                w_mergedWord[8*b +: 8] = bus.data_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept && bus.data_wr) begin
            r_mem[w_wordIdx] <= w_mergedWord;
        end
    end

    // Every entry counts down each cycle; a freshly pushed entry restarts at LATENCY-1.
    always_comb begin
        w_qWrNext   = r_qWr;
        w_qDataNext = r_qData;
        for (int i = 0; i < DEPTH; i++) begin
            w_qWaitNext[i] = (r_qWait[i] != '0) ? (r_qWait[i] - 1'b1) : '0;
        end
        if (w_accept) begin
            w_qWrNext[r_wrPtr]   = bus.data_wr;
            w_qDataNext[r_wrPtr] = bus.data_wr ? 32'd0 : w_memWord;
            w_qWaitNext[r_wrPtr] = INIT_WAIT;
        end
    end

    always_ff @(posedge clk) begin
        r_qWr   <= w_qWrNext;
        r_qData <= w_qDataNext;
        r_qWait <= w_qWaitNext;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_count <= '0;
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_accept) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_dataOk) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (w_accept && !w_dataOk) begin
                r_count <= r_count + 1'b1;
            end else if (!w_accept && w_dataOk) begin
                r_count <= r_count - 1'b1;
            end
        end
    end
endmodule
